// File: rtl/display_scan_pkg.sv
// ============================================================================
// Module  : display_scan_pkg
// Brief   : Shared constants, state encoding and digit helper for the scan driver.
// Revision: 1.0
// ============================================================================
`default_nettype none

package display_scan_pkg;

  localparam logic [6:0] SEG_ZERO  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] DIGIT_ROW_ONES = 2'd0;
  localparam logic [1:0] DIGIT_ROW_TENS = 2'd1;
  localparam logic [1:0] DIGIT_COL_ONES = 2'd2;
  localparam logic [1:0] DIGIT_COL_TENS = 2'd3;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Snapshot layout is {column tens, column ones, row tens, row ones}.
  function automatic logic [6:0] digit_code(input logic [27:0] snapshot,
                                            input logic [1:0]  index);
    logic [6:0] code;
    code = SEG_BLANK;
    case (index)
      DIGIT_ROW_ONES: code = snapshot[6:0];
      DIGIT_ROW_TENS: code = snapshot[13:7];
      DIGIT_COL_ONES: code = snapshot[20:14];
      DIGIT_COL_TENS: code = snapshot[27:21];
      default:        code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_phase_counter.sv
// ============================================================================
// Module  : scan_phase_counter
// Brief   : 16-bit phase counter with synchronous clear and terminal-count flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module scan_phase_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic [15:0] terminal,
  output logic        terminal_count
);

  logic [15:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= 16'd0;
    end else if (clear) begin
      r_count <= 16'd0;
    end else begin
      r_count <= r_count + 16'd1;
    end
  end

  assign terminal_count = (r_count == terminal);

endmodule

`default_nettype wire

// File: rtl/display_scan_driver.sv
// ============================================================================
// Module  : display_scan_driver
// Brief   : Four-digit seven-segment scan driver with per-frame input snapshot.
//           Optional DISPLAY_SCAN_LEADING_ZERO_BLANK_EN blanks zero tens digits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module display_scan_driver
  import display_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [13:0] row_display,
  input  logic [13:0] column_display,
  output logic [6:0]  seg,
  output logic [3:0]  digit_select,
  output logic        frame_tick
);

  localparam logic [15:0] c_SHOW_TERM  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] c_BLANK_TERM = 16'(BLANK_CYCLES - 1);

  scan_state_t r_state;
  scan_state_t w_state_next;
  logic [1:0]  r_index;
  logic [1:0]  w_index_next;
  logic [27:0] r_snapshot;
  logic        w_capture;
  logic [6:0]  r_seg;
  logic [6:0]  w_seg_next;
  logic [3:0]  r_digit_select;
  logic [3:0]  w_digit_select_next;
  logic        r_frame_tick;
  logic [15:0] w_terminal;
  logic        w_terminal_count;
  logic [6:0]  w_digit_raw;
  logic [6:0]  w_digit_code;

  assign w_terminal = (r_state == ST_BLANK) ? c_BLANK_TERM : c_SHOW_TERM;

  // Both phase transitions restart the shared counter.
  scan_phase_counter u_phase_counter (
    .clock          (clock),
    .reset          (reset),
    .clear          (w_terminal_count),
    .terminal       (w_terminal),
    .terminal_count (w_terminal_count)
  );

  assign w_digit_raw = digit_code(r_snapshot, r_index);

`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
  // Odd indices are the tens digits.
  assign w_digit_code = (r_index[0] && (w_digit_raw == SEG_ZERO)) ? SEG_BLANK : w_digit_raw;
`else
  assign w_digit_code = w_digit_raw;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_BLANK;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_index_next        = r_index;
    w_capture           = 1'b0;
    w_seg_next          = SEG_BLANK;
    w_digit_select_next = 4'b1111;
    case (r_state)
      ST_BLANK: begin
        if (w_terminal_count) begin
          w_state_next = ST_SHOW;
          w_capture    = (r_index == DIGIT_ROW_ONES);
        end
      end
      ST_SHOW: begin
        w_digit_select_next = ~(4'b0001 << r_index);
        w_seg_next          = w_digit_code;
        if (w_terminal_count) begin
          w_state_next = ST_BLANK;
          w_index_next = r_index + 2'd1;
        end
      end
      default: begin
        w_state_next = ST_BLANK;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_index        <= DIGIT_ROW_ONES;
      r_snapshot     <= 28'd0;
      r_seg          <= SEG_BLANK;
      r_digit_select <= 4'b1111;
      r_frame_tick   <= 1'b0;
    end else begin
      r_index        <= w_index_next;
      r_seg          <= w_seg_next;
      r_digit_select <= w_digit_select_next;
      r_frame_tick   <= w_capture;
      if (w_capture) begin
        r_snapshot <= {column_display, row_display};
      end
    end
  end

  assign seg          = r_seg;
  assign digit_select = r_digit_select;
  assign frame_tick   = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_driver.sv
// ============================================================================
// Module  : tb_display_scan_driver
// Brief   : Self-checking bench for display_scan_driver (SCAN_DIV=4, BLANK_CYCLES=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_display_scan_driver;

  localparam int SD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = SD + BC;
  localparam int FRAME = 4 * SLOT;

  logic        clock = 1'b0;
  logic        reset;
  logic [13:0] row_display;
  logic [13:0] column_display;
  logic [6:0]  seg;
  logic [3:0]  digit_select;
  logic        frame_tick;

  always #5 clock = ~clock;

  display_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clock          (clock),
    .reset          (reset),
    .row_display    (row_display),
    .column_display (column_display),
    .seg            (seg),
    .digit_select   (digit_select),
    .frame_tick     (frame_tick)
  );

  typedef struct {
    logic [6:0] seg;
    logic [3:0] dsel;
    logic       tick;
  } exp_t;

  typedef struct {
    logic [13:0] row;
    logic [13:0] col;
    logic [6:0]  digit [4];
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  exp_t        sbq[$];
  int          j;
  logic [27:0] snap_m;
  logic [6:0]  seen [4];
  vec_t        vecs [3];

  function automatic logic [6:0] model_digit(input logic [27:0] s, input int d);
    logic [6:0] c;
    c = s[7*d +: 7];
`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
    if ((d == 1 || d == 3) && c == 7'b0111111) c = 7'b0000000;
`endif
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected outputs for the next cycle come from the cycle position within
  // the frame: slot = SCAN_DIV + BLANK_CYCLES, blank occupies the first BC cycles.
  task automatic tick();
    exp_t       e;
    int         pos;
    int         dig;
    logic [3:0] one;
    int         lows;
    pos    = j % SLOT;
    dig    = (j / SLOT) % 4;
    one    = 4'b0001 << dig;
    e.tick = (dig == 0) && (pos == BC - 1);
    e.dsel = (pos >= BC) ? ~one : 4'b1111;
    e.seg  = (pos >= BC) ? model_digit(snap_m, dig) : 7'b0000000;
    sbq.push_back(e);
    if (e.tick) snap_m = {column_display, row_display};
    @(posedge clock);
    j++;
    @(negedge clock);
    e = sbq.pop_front();
    check("seg", 32'(seg), 32'(e.seg));
    check("digit_select", 32'(digit_select), 32'(e.dsel));
    check("frame_tick", 32'(frame_tick), 32'(e.tick));
    lows = 0;
    for (int b = 0; b < 4; b++) if (!digit_select[b]) lows++;
    check("one_hot_low", 32'(lows <= 1), 32'd1);
    if (digit_select == 4'b1111) check("blank_seg", 32'(seg), 32'd0);
    for (int d = 0; d < 4; d++) begin
      logic [3:0] m;
      m = ~(4'b0001 << d);
      if (digit_select == m) seen[d] = seg;
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_tick !== 1'b1 && n < 2 * FRAME);
    check("frame_tick_timeout", 32'(frame_tick), 32'd1);
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    j      = 0;
    snap_m = 28'd0;
    sbq.delete();
  endtask

  task automatic check_startup();
    int first_tick;
    int first_d0;
    int first_d1;
    first_tick = -1;
    first_d0   = -1;
    first_d1   = -1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (frame_tick === 1'b1 && first_tick < 0) first_tick = k;
      if (digit_select === 4'b1110 && first_d0 < 0) first_d0 = k;
      if (digit_select === 4'b1101 && first_d1 < 0) first_d1 = k;
    end
    check("first_frame_tick_cycle", 32'(first_tick), 32'd2);
    check("first_digit0_cycle", 32'(first_d0), 32'd3);
    check("first_digit1_cycle", 32'(first_d1), 32'd9);
  endtask

  initial begin
    vecs[0].row = 14'h0000;
    vecs[0].col = 14'h0000;
    vecs[0].digit = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    vecs[1].row = {7'b0000110, 7'b1011011};
    vecs[1].col = {7'b1001111, 7'b1100110};
    vecs[1].digit = '{7'b1011011, 7'b0000110, 7'b1100110, 7'b1001111};
    vecs[2].row = {7'b0111111, 7'b1111111};
    vecs[2].col = {7'b0111111, 7'b0000111};
`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
    vecs[2].digit = '{7'b1111111, 7'b0000000, 7'b0000111, 7'b0000000};
`else
    vecs[2].digit = '{7'b1111111, 7'b0111111, 7'b0000111, 7'b0111111};
`endif

    reset          = 1'b0;
    row_display    = 14'h0000;
    column_display = 14'h0000;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_seg", 32'(seg), 32'd0);
    check("reset_digit_select", 32'(digit_select), 32'hF);
    check("reset_frame_tick", 32'(frame_tick), 32'd0);

    release_reset();
    check_startup();

    foreach (vecs[v]) begin
      row_display    = vecs[v].row;
      column_display = vecs[v].col;
      wait_tick();
      for (int d = 0; d < 4; d++) seen[d] = 7'h7F;
      repeat (FRAME) tick();
      for (int d = 0; d < 4; d++) check($sformatf("vec%0d_digit%0d", v, d), 32'(seen[d]), 32'(vecs[v].digit[d]));
    end

    // Input change one cycle after capture must wait for the next frame.
    row_display    = vecs[1].row;
    column_display = vecs[1].col;
    wait_tick();
    tick();
    row_display = {7'b1110111, 7'b1111100};
    for (int d = 0; d < 4; d++) seen[d] = 7'h7F;
    repeat (FRAME - 2) tick();
    check("no_tear_digit0", 32'(seen[0]), 32'(vecs[1].digit[0]));
    check("no_tear_digit1", 32'(seen[1]), 32'(vecs[1].digit[1]));
    wait_tick();
    repeat (FRAME) tick();
    check("next_frame_digit0", 32'(seen[0]), 32'b1111100);
    check("next_frame_digit1", 32'(seen[1]), 32'b1110111);

    // Reset while digit 2 is lit blanks immediately.
    begin
      int n;
      n = 0;
      while (digit_select !== 4'b1011 && n < 2 * FRAME) begin
        tick();
        n++;
      end
      check("reach_digit2", 32'(digit_select), 32'hB);
    end
    #2 reset = 1'b0;
    #1;
    check("midshow_reset_dsel", 32'(digit_select), 32'hF);
    check("midshow_reset_seg", 32'(seg), 32'd0);
    check("midshow_reset_tick", 32'(frame_tick), 32'd0);
    release_reset();
    check_startup();
    repeat (FRAME) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=<200000", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
